// File: rtl/poly_solver_if.sv
// Start/completed handshake bundle for the Horner polynomial evaluator.
// The master issues operands and start; the slave returns the result and its status flags.
interface poly_solver_if #(
    parameter int XW     = 8,
    parameter int DW     = 16,
    parameter int DEGREE = 2
) ();
    logic                       start;
    logic [XW-1:0]              X;
    logic [(DEGREE+1)*DW-1:0]   coef;
    logic [DW-1:0]              result;
    logic                       zero;
    logic                       overflow;
    logic                       completed;
    logic                       busy;

    modport master (
        output start, X, coef,
        input  result, zero, overflow, completed, busy
    );

    modport slave (
        input  start, X, coef,
        output result, zero, overflow, completed, busy
    );
endinterface

// File: rtl/poly_solver.sv
// Sequential polynomial evaluator using Horner's method, one multiply-accumulate per clock.
// Handles signed or unsigned operands and reports an overflow flag that stays set for the whole evaluation.
module poly_solver #(
    parameter int XW     = 8,
    parameter int DW     = 16,
    parameter int DEGREE = 2,
    parameter int SIGNED = 0
) (
    input  logic         clk,
    input  logic         rst,
    poly_solver_if.slave bus
);
    // One extra bit over the exact product width holds acc*X + c without loss.
    localparam int W  = DW + XW + 1;
    localparam int CW = $clog2(DEGREE + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_reg, state_next;
    logic [XW-1:0]        x_reg, x_next;
    logic [DEGREE*DW-1:0] coef_reg, coef_next;
    logic [DW-1:0]        acc_reg, acc_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic                 ovf_reg, ovf_next;
    logic [DW-1:0]        result_reg, result_next;
    logic                 zero_reg, zero_next;
    logic                 overflow_reg, overflow_next;
    logic                 completed_reg, completed_next;
    logic                 busy_reg, busy_next;

    logic [DW-1:0] coef_arr [0:DEGREE-1];
    logic [CW-1:0] idx;
    logic [DW-1:0] c_sel;
    logic [W-1:0]  acc_ext, x_ext, c_ext, prod, sum;
    logic          step_ovf;

    // c[DEGREE] seeds the accumulator directly, so only the lower terms are kept.
    genvar gi;
    generate
        for (gi = 0; gi < DEGREE; gi++) begin : g_unpack
            assign coef_arr[gi] = coef_reg[gi*DW +: DW];
        end
    endgenerate

    assign idx   = cnt_reg - CW'(1);
    assign c_sel = coef_arr[idx];

    generate
        if (SIGNED != 0) begin : g_sext
            assign acc_ext  = {{(W-DW){acc_reg[DW-1]}}, acc_reg};
            assign x_ext    = {{(W-XW){x_reg[XW-1]}}, x_reg};
            assign c_ext    = {{(W-DW){c_sel[DW-1]}}, c_sel};
            assign step_ovf = !((&sum[W-1:DW-1]) || !(|sum[W-1:DW-1]));
        end else begin : g_zext
            assign acc_ext  = {{(W-DW){1'b0}}, acc_reg};
            assign x_ext    = {{(W-XW){1'b0}}, x_reg};
            assign c_ext    = {{(W-DW){1'b0}}, c_sel};
            assign step_ovf = |sum[W-1:DW];
        end
    endgenerate

    // Modular W-bit arithmetic is exact here because the true value always fits in W bits.
    assign prod = acc_ext * x_ext;
    assign sum  = prod + c_ext;

    always_comb begin
        state_next     = state_reg;
        x_next         = x_reg;
        coef_next      = coef_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        ovf_next       = ovf_reg;
        result_next    = result_reg;
        zero_next      = zero_reg;
        overflow_next  = overflow_reg;
        completed_next = completed_reg;
        busy_next      = busy_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next     = CALC;
                    x_next         = bus.X;
                    coef_next      = bus.coef[DEGREE*DW-1:0];
                    acc_next       = bus.coef[DEGREE*DW +: DW];
                    cnt_next       = CW'(DEGREE);
                    ovf_next       = 1'b0;
                    completed_next = 1'b0;
                    busy_next      = 1'b1;
                end
            end
            CALC: begin
                acc_next = sum[DW-1:0];
                cnt_next = cnt_reg - CW'(1);
                ovf_next = ovf_reg | step_ovf;
                if (cnt_reg == CW'(1)) begin
                    state_next     = DONE;
                    result_next    = sum[DW-1:0];
                    zero_next      = (sum[DW-1:0] == '0);
                    overflow_next  = ovf_reg | step_ovf;
                    completed_next = 1'b1;
                    busy_next      = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            x_reg         <= '0;
            coef_reg      <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            completed_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            x_reg         <= x_next;
            coef_reg      <= coef_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            ovf_reg       <= ovf_next;
            result_reg    <= result_next;
            zero_reg      <= zero_next;
            overflow_reg  <= overflow_next;
            completed_reg <= completed_next;
            busy_reg      <= busy_next;
        end
    end

    assign bus.result    = result_reg;
    assign bus.zero      = zero_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.completed = completed_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_poly_solver.sv
// Scoreboard bench: an unsigned degree-2 evaluator and a signed degree-3 evaluator.
// Directed vectors use hand-computed results, and a monitor checks every completion.
module tb_poly_solver;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    poly_solver_if #(.XW(8), .DW(16), .DEGREE(2)) ifa ();
    poly_solver_if #(.XW(8), .DW(16), .DEGREE(3)) ifb ();

    poly_solver #(.XW(8), .DW(16), .DEGREE(2), .SIGNED(0)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    poly_solver #(.XW(8), .DW(16), .DEGREE(3), .SIGNED(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        o;
        string       name;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea, eb;
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] last_res_a = 16'h0;
    logic [15:0] last_res_b = 16'h0;
    logic        comp_prev_a = 1'b0;
    logic        comp_prev_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: every rising edge of completed pops one expected response.
    always @(negedge clk) begin
        if (ifa.completed === 1'b1 && !comp_prev_a) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_completion: got result 0x%04h expected no completion", ifa.result);
            end else begin
                ea = qa.pop_front();
                $display("a %s: result=0x%04h zero=%0b overflow=%0b (want 0x%04h %0b %0b)",
                         ea.name, ifa.result, ifa.zero, ifa.overflow, ea.res, ea.z, ea.o);
                check({ea.name, "_result"},   32'(ifa.result),   32'(ea.res));
                check({ea.name, "_zero"},     32'(ifa.zero),     32'(ea.z));
                check({ea.name, "_overflow"}, 32'(ifa.overflow), 32'(ea.o));
            end
        end
        comp_prev_a <= (ifa.completed === 1'b1);
    end

    always @(negedge clk) begin
        if (ifb.completed === 1'b1 && !comp_prev_b) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_completion: got result 0x%04h expected no completion", ifb.result);
            end else begin
                eb = qb.pop_front();
                $display("b %s: result=0x%04h zero=%0b overflow=%0b (want 0x%04h %0b %0b)",
                         eb.name, ifb.result, ifb.zero, ifb.overflow, eb.res, eb.z, eb.o);
                check({eb.name, "_result"},   32'(ifb.result),   32'(eb.res));
                check({eb.name, "_zero"},     32'(ifb.zero),     32'(eb.z));
                check({eb.name, "_overflow"}, 32'(ifb.overflow), 32'(eb.o));
            end
        end
        comp_prev_b <= (ifb.completed === 1'b1);
    end

    task automatic run_a(input string name, input logic [7:0] x, input logic [47:0] cf,
                         input logic [15:0] r, input logic z, input logic o);
        exp_t e;
        int   lat;
        e.res = r; e.z = z; e.o = o; e.name = name;
        @(negedge clk);
        ifa.X = x; ifa.coef = cf; ifa.start = 1'b1;
        qa.push_back(e);
        @(posedge clk); #1;
        ifa.start = 1'b0; ifa.X = ~x; ifa.coef = ~cf;
        check({name, "_busy_set"},       32'(ifa.busy),      32'd1);
        check({name, "_completed_drop"}, 32'(ifa.completed), 32'd0);
        check({name, "_result_held"},    32'(ifa.result),    32'(last_res_a));
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (ifa.completed !== 1'b1 && lat < 10);
        check({name, "_latency"},   32'(lat),      32'd2);
        check({name, "_busy_clear"}, 32'(ifa.busy), 32'd0);
        last_res_a = r;
    endtask

    task automatic run_b(input string name, input logic [7:0] x, input logic [63:0] cf,
                         input logic [15:0] r, input logic z, input logic o);
        exp_t e;
        int   lat;
        e.res = r; e.z = z; e.o = o; e.name = name;
        @(negedge clk);
        ifb.X = x; ifb.coef = cf; ifb.start = 1'b1;
        qb.push_back(e);
        @(posedge clk); #1;
        ifb.start = 1'b0; ifb.X = ~x; ifb.coef = ~cf;
        check({name, "_busy_set"},    32'(ifb.busy),   32'd1);
        check({name, "_result_held"}, 32'(ifb.result), 32'(last_res_b));
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (ifb.completed !== 1'b1 && lat < 10);
        check({name, "_latency"},   32'(lat),      32'd3);
        check({name, "_busy_clear"}, 32'(ifb.busy), 32'd0);
        last_res_b = r;
    endtask

    task automatic check_cleared(input string name);
        check({name, "_a_result"},    32'(ifa.result),    32'd0);
        check({name, "_a_zero"},      32'(ifa.zero),      32'd0);
        check({name, "_a_overflow"},  32'(ifa.overflow),  32'd0);
        check({name, "_a_completed"}, 32'(ifa.completed), 32'd0);
        check({name, "_a_busy"},      32'(ifa.busy),      32'd0);
        check({name, "_b_result"},    32'(ifb.result),    32'd0);
        check({name, "_b_completed"}, 32'(ifb.completed), 32'd0);
        check({name, "_b_busy"},      32'(ifb.busy),      32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ifa.start = 1'b0; ifa.X = '0; ifa.coef = '0;
        ifb.start = 1'b0; ifb.X = '0; ifb.coef = '0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;

        // Unsigned degree 2: 2*9 + 5*3 + 7 = 40.
        run_a("basic", 8'd3, {16'd2, 16'd5, 16'd7}, 16'h0028, 1'b0, 1'b0);
        // 0xFFFF*255 overflows; truncated chain ends at 0x01FF.
        run_a("ovf", 8'd255, {16'hFFFF, 16'h0000, 16'h0000}, 16'h01FF, 1'b0, 1'b1);
        run_a("zero", 8'd0, {16'd9, 16'd4, 16'd0}, 16'h0000, 1'b1, 1'b0);
        run_a("ones", 8'd1, {16'd1, 16'd1, 16'd1}, 16'h0003, 1'b0, 1'b0);

        // A second start while busy must be ignored: only 1*4+0*2+0 = 4 completes.
        begin
            exp_t e;
            e.res = 16'h0004; e.z = 1'b0; e.o = 1'b0; e.name = "ignore";
            @(negedge clk);
            ifa.X = 8'd2; ifa.coef = {16'd1, 16'd0, 16'd0}; ifa.start = 1'b1;
            qa.push_back(e);
            @(posedge clk); #1;
            ifa.X = 8'd5; ifa.coef = {16'd3, 16'd3, 16'd3};
            @(posedge clk); #1;
            @(posedge clk); #1;
            ifa.start = 1'b0;
            check("ignore_completed", 32'(ifa.completed), 32'd1);
            check("ignore_busy",      32'(ifa.busy),      32'd0);
            repeat (3) @(posedge clk);
            #1;
            check("ignore_still_done", 32'(ifa.result), 32'h0004);
            last_res_a = 16'h0004;
        end

        // Reset in the middle of an evaluation aborts it.
        @(negedge clk);
        ifa.X = 8'd3; ifa.coef = {16'd2, 16'd5, 16'd7}; ifa.start = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_cleared("rst_calc");
        last_res_a = 16'h0;
        run_a("after_rst", 8'd3, {16'd2, 16'd5, 16'd7}, 16'h0028, 1'b0, 1'b0);

        // Reset and start on the same edge: reset wins.
        @(negedge clk);
        rst = 1'b1;
        ifa.X = 8'd1; ifa.coef = {16'd1, 16'd1, 16'd1}; ifa.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ifa.start = 1'b0;
        check_cleared("rst_start");
        @(posedge clk); #1;
        check("rst_start_no_busy", 32'(ifa.busy), 32'd0);
        last_res_a = 16'h0;

        // Signed degree 3 at X=-2: 1*(-8) - 3 = -11.
        run_b("s_basic", 8'hFE, {16'h0001, 16'h0000, 16'h0000, 16'hFFFD}, 16'hFFF5, 1'b0, 1'b0);
        // 0x4000 -> -32768 -> +65536 overflows to 0 -> -3.
        run_b("s_ovf", 8'hFE, {16'h4000, 16'h0000, 16'h0000, 16'hFFFD}, 16'hFFFD, 1'b0, 1'b1);
        // X=2: ((0*2+0)*2-1)*2+5 = 3.
        run_b("s_mixed", 8'h02, {16'h0000, 16'h0000, 16'hFFFF, 16'h0005}, 16'h0003, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("a_queue_drained", 32'(qa.size()), 32'd0);
        check("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
